// File: rtl/spi_ram_pkg.sv
// Shared types and constants for the SPI-to-RAM slice: FSM encoding, command codes, word widths.
// Imported by the SPI slave front end and the single-port RAM.
package spi_ram_pkg;

  localparam int RAM_DATA_W = 8;
  localparam int RAM_CMD_W  = 2;
  localparam int RAM_WORD_W = RAM_DATA_W + RAM_CMD_W;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    CHK_CMD   = 3'b001,
    WRITE     = 3'b010,
    READ_ADD  = 3'b011,
    READ_DATA = 3'b100
  } state_t;

  // Sub-phase inside the three word-receiving states.
  typedef enum logic [1:0] {
    PH_RX   = 2'b00,
    PH_WAIT = 2'b01,
    PH_TX   = 2'b10,
    PH_DONE = 2'b11
  } phase_t;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_if.sv
// SPI mode-0 slave: deserialises 10-bit command words (rx_valid on the 11th edge after SS_n falls)
// and shifts a RAM read-data byte out on MISO; SS_n high aborts any frame back to IDLE.
module spi_slave_if
  import spi_ram_pkg::*;
#(
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid
);

  localparam int         WORD_W  = DATA_W + 2;
  localparam logic [3:0] RX_LAST = 4'(WORD_W - 1);
  localparam logic [3:0] TX_LAST = 4'(DATA_W);

  state_t              r_state, w_state_nxt;
  phase_t              r_phase, w_phase_nxt;
  logic [3:0]          r_cnt, w_cnt_nxt;
  logic [WORD_W-2:0]   r_shift, w_shift_nxt;
  logic [DATA_W-1:0]   r_tx, w_tx_nxt;
  logic                r_miso, w_miso_nxt;
  logic [WORD_W-1:0]   r_rx_data, w_rx_data_nxt;
  logic                r_rx_valid, w_rx_valid_nxt;
  logic                r_rd_seen, w_rd_seen_nxt;
  logic [WORD_W-1:0]   w_word;

  // The last bit is taken straight from MOSI so the word is complete on its own edge.
  assign w_word = {r_shift, MOSI};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_phase    <= PH_RX;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_tx       <= '0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rd_seen  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_phase    <= w_phase_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
      r_miso     <= w_miso_nxt;
      r_rx_data  <= w_rx_data_nxt;
      r_rx_valid <= w_rx_valid_nxt;
      r_rd_seen  <= w_rd_seen_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_phase_nxt    = r_phase;
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_shift;
    w_tx_nxt       = r_tx;
    w_miso_nxt     = 1'b0;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = 1'b0;
    w_rd_seen_nxt  = r_rd_seen;

    if (SS_n) begin
      w_state_nxt = IDLE;
      w_phase_nxt = PH_RX;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = CHK_CMD;
          w_phase_nxt = PH_RX;
          w_cnt_nxt   = '0;
        end

        CHK_CMD: begin
          w_shift_nxt = {{(WORD_W-2){1'b0}}, MOSI};
          w_cnt_nxt   = 4'd1;
          w_phase_nxt = PH_RX;
          // Only the top command bit steers; bit 8 is left for the RAM to decode.
          if (MOSI != CMD_RD_ADDR[1])
            w_state_nxt = WRITE;
          else if (r_rd_seen)
            w_state_nxt = READ_DATA;
          else
            w_state_nxt = READ_ADD;
        end

        WRITE, READ_ADD, READ_DATA: begin
          case (r_phase)
            PH_RX: begin
              w_shift_nxt = {r_shift[WORD_W-3:0], MOSI};
              w_cnt_nxt   = r_cnt + 4'd1;
              if (r_cnt == RX_LAST) begin
                w_rx_data_nxt  = w_word;
                w_rx_valid_nxt = 1'b1;
                w_cnt_nxt      = '0;
                w_phase_nxt    = (r_state == READ_DATA) ? PH_WAIT : PH_DONE;
                if (r_state == READ_ADD)
                  w_rd_seen_nxt = 1'b1;
              end
            end

            PH_WAIT: begin
              if (tx_valid) begin
                w_miso_nxt  = tx_data[DATA_W-1];
                w_tx_nxt    = {tx_data[DATA_W-2:0], 1'b0};
                w_cnt_nxt   = 4'd1;
                w_phase_nxt = PH_TX;
              end
            end

            PH_TX: begin
              if (r_cnt == TX_LAST) begin
                w_rd_seen_nxt = 1'b0;
                w_cnt_nxt     = '0;
                w_phase_nxt   = PH_DONE;
              end else begin
                w_miso_nxt = r_tx[DATA_W-1];
                w_tx_nxt   = {r_tx[DATA_W-2:0], 1'b0};
                w_cnt_nxt  = r_cnt + 4'd1;
              end
            end

            default: begin
            end
          endcase
        end

        default: begin
          w_state_nxt = IDLE;
          w_phase_nxt = PH_RX;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: frame table with a spec-level model of rd_addr_seen and a word scoreboard.
module tb_spi_slave_if;
  import spi_ram_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       SS_n = 1'b1;
  logic       MOSI = 1'b0;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  spi_slave_if #(.DATA_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
  );

  typedef struct {
    logic [9:0] word;
    int         nbits;
    int         extra;
    bit         tx_during;
    int         tx_delay;
    logic [7:0] tx_byte;
    int         tx_stop;
  } vec_t;

  vec_t vecs[12];

  logic [9:0] sb_q[$];
  logic [9:0] sb_exp;
  int         pulses = 0;

  bit         m_rd_seen = 1'b0;
  logic [9:0] m_last = 10'h000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && rx_valid === 1'b1) begin
      pulses++;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: rx_valid with rx_data=%0h, none expected", rx_data);
      end else begin
        sb_exp = sb_q.pop_front();
        chk("sb_word", {22'd0, rx_data}, {22'd0, sb_exp});
      end
    end
  end

  task automatic run_vec(input vec_t v, input int idx);
    int p0;
    bit route_rd;
    bit full;
    p0       = pulses;
    route_rd = v.word[9] && m_rd_seen;
    full     = (v.nbits >= 10);

    SS_n     = 1'b0;
    tx_valid = v.tx_during;
    tx_data  = v.tx_during ? 8'hFF : 8'($urandom);
    MOSI     = 1'($urandom);
    step();
    for (int i = 0; i < v.nbits && i < 10; i++) begin
      MOSI = v.word[9-i];
      if (i == 9) sb_q.push_back(v.word);
      step();
      chk($sformatf("v%0d_miso_rx", idx), {31'd0, MISO}, 32'd0);
      chk($sformatf("v%0d_rxv_b%0d", idx, i), {31'd0, rx_valid}, (i == 9) ? 32'd1 : 32'd0);
      if (i == 9) chk($sformatf("v%0d_rx_data", idx), {22'd0, rx_data}, {22'd0, v.word});
    end
    tx_valid = 1'b0;

    if (full) begin
      m_last = v.word;
      if (v.word[9] && !route_rd) m_rd_seen = 1'b1;
    end

    if (full && v.tx_delay > 0) begin
      for (int d = 1; d < v.tx_delay; d++) begin
        MOSI = 1'($urandom);
        step();
        chk($sformatf("v%0d_miso_wait", idx), {31'd0, MISO}, 32'd0);
        chk($sformatf("v%0d_rxv_once", idx), {31'd0, rx_valid}, 32'd0);
      end
      for (int k = 0; k < v.tx_stop; k++) begin
        if (k == 0) begin
          tx_valid = 1'b1;
          tx_data  = v.tx_byte;
        end else begin
          tx_valid = 1'($urandom);
          tx_data  = 8'($urandom);
        end
        MOSI = 1'($urandom);
        step();
        chk($sformatf("v%0d_miso_tx%0d", idx, k), {31'd0, MISO},
            route_rd ? {31'd0, v.tx_byte[7-k]} : 32'd0);
      end
      tx_valid = 1'b0;
      if (v.tx_stop == 8) begin
        step();
        chk($sformatf("v%0d_miso_post", idx), {31'd0, MISO}, 32'd0);
        if (route_rd) m_rd_seen = 1'b0;
      end
    end

    for (int e = 0; e < v.extra; e++) begin
      MOSI = 1'($urandom);
      step();
      chk($sformatf("v%0d_miso_extra", idx), {31'd0, MISO}, 32'd0);
      chk($sformatf("v%0d_rxv_extra", idx), {31'd0, rx_valid}, 32'd0);
    end

    SS_n = 1'b1;
    step();
    chk($sformatf("v%0d_miso_end", idx), {31'd0, MISO}, 32'd0);
    chk($sformatf("v%0d_rxv_end", idx), {31'd0, rx_valid}, 32'd0);
    chk($sformatf("v%0d_rx_hold", idx), {22'd0, rx_data}, {22'd0, m_last});
    chk($sformatf("v%0d_state", idx), {29'd0, dut.r_state}, {29'd0, IDLE});
    chk($sformatf("v%0d_rd_seen", idx), {31'd0, dut.r_rd_seen}, {31'd0, m_rd_seen});
    chk($sformatf("v%0d_pulses", idx), 32'(pulses - p0), full ? 32'd1 : 32'd0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    //          word    nbits extra spur delay byte  stop
    vecs[0]  = '{10'h0A5, 10, 3, 1'b0, 0, 8'h00, 8};
    vecs[1]  = '{10'h13C, 10, 0, 1'b0, 0, 8'h00, 8};
    vecs[2]  = '{10'h155,  5, 0, 1'b0, 0, 8'h00, 8};
    vecs[3]  = '{10'h2A5, 10, 0, 1'b0, 0, 8'h00, 8};
    vecs[4]  = '{10'h300, 10, 0, 1'b0, 1, 8'hC3, 8};
    vecs[5]  = '{10'h0F0, 10, 2, 1'b1, 1, 8'hFF, 8};
    vecs[6]  = '{10'h3C7, 10, 0, 1'b0, 1, 8'h5A, 8};
    vecs[7]  = '{10'h311, 10, 1, 1'b0, 3, 8'h96, 8};
    vecs[8]  = '{10'h2FF, 10, 0, 1'b0, 0, 8'h00, 8};
    vecs[9]  = '{10'h3AA, 10, 0, 1'b0, 2, 8'hE1, 3};
    vecs[10] = '{10'h3FF,  7, 0, 1'b0, 0, 8'h00, 8};
    vecs[11] = '{10'h37E, 10, 0, 1'b0, 1, 8'h5A, 8};

    // Reset wins over an active-low SS_n with MOSI toggling.
    rst_n = 1'b0;
    SS_n  = 1'b0;
    for (int r = 0; r < 2; r++) begin
      MOSI = r[0];
      step();
    end
    chk("rst_miso", {31'd0, MISO}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {22'd0, rx_data}, 32'd0);
    chk("rst_state", {29'd0, dut.r_state}, {29'd0, IDLE});
    chk("rst_cnt", {28'd0, dut.r_cnt}, 32'd0);
    chk("rst_rd_seen", {31'd0, dut.r_rd_seen}, 32'd0);
    SS_n  = 1'b1;
    rst_n = 1'b1;
    step();
    chk("idle_hold", {29'd0, dut.r_state}, {29'd0, IDLE});

    for (int n = 0; n < 12; n++) run_vec(vecs[n], n);

    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_slave_if.md
Name: spi_slave_if

Overview:
Serial front end for the single-port RAM. It deserialises 10-bit command words from MOSI (mode 0, MSB first) and presents them to the RAM as rx_data/rx_valid. For read-data frames it accepts the RAM's 8-bit tx_data/tx_valid reply and shifts it out on MISO. It is clocked directly by the SPI clock and sits between the pads and the RAM.

Parameters:
DATA_W, 8, payload width; rx_data is DATA_W+2 bits (2-bit command plus payload), tx_data is DATA_W bits.

Ports:
clk  in  1  SPI serial clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
SS_n  in  1  slave select, active-low; high aborts or ends a frame
MOSI  in  1  serial data in, MSB first
MISO  out  1  serial data out, MSB first
rx_data  out  DATA_W+2  assembled word {cmd[1:0], payload}
rx_valid  out  1  one-cycle strobe; rx_data is valid while it is high
tx_data  in  DATA_W  read data from the RAM
tx_valid  in  1  tx_data is valid (RAM read-data reply)

Behaviour:
- Reset (rst_n=0 at an edge): state=IDLE, MISO=0, rx_valid=0, rx_data=0, bit counter=0, rd_addr_seen=0. Reset overrides SS_n.
- Command codes in rx_data[9:8]: 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE: SS_n=0 -> CHK_CMD; otherwise stay. Nothing is sampled on this edge.
- CHK_CMD: sample MOSI into shift[9], then branch: MOSI=0 -> WRITE; MOSI=1 and rd_addr_seen=0 -> READ_ADD; MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE, READ_ADD, READ_DATA: shift MOSI in on each of the next 9 edges (bits 8..0).
  - On the edge that captures bit 0 (the 10th sampled bit, i.e. the 11th edge after SS_n falls), rx_data <= full word and rx_valid <= 1.
  - rx_valid drops on the next edge. Exactly one rx_valid per frame.
  - rx_data holds its value until the next completed word.
- READ_ADD completion sets rd_addr_seen=1.
- READ_DATA reply:
  - After rx_valid, the block waits in a response phase. On the first edge with tx_valid=1, it loads tx_data and drives MISO=tx_data[7].
  - The next 7 edges drive bits 6..0.
  - After bit 0, MISO=0 and rd_addr_seen clears.
  - tx_valid is ignored in every other state or phase.
  - If tx_valid never arrives, MISO stays 0 until SS_n rises.
- Extra bits after a completed word, or after the reply, are ignored: no second rx_valid, MISO=0, state held until SS_n=1.
- SS_n=1 in any state -> IDLE on that edge, counter=0, MISO=0, rx_valid=0.
  - A partial word gives no rx_valid.
  - rd_addr_seen is unchanged by an abort; an aborted reply does not clear it.
- The command bit sampled in CHK_CMD selects the branch. Bit 8 is not checked by this block: a word whose bit 9 = 1 follows the rd_addr_seen flag, whatever its code.
- MISO is registered and changes only on rising edges.

Decomposition:
- Shared package spi_ram_pkg holds:
  - the state encoding (IDLE=3'b000, CHK_CMD=3'b001, WRITE=3'b010, READ_ADD=3'b011, READ_DATA=3'b100);
  - the command code constants (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA);
  - the word-width constants, shared with the RAM.
- No sub-module. The FSM, the 4-bit bit counter and the shift/output registers stay in one module.
- A separate spi_ram_top, not part of this block, instantiates this block and the RAM.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with SS_n=0 and MOSI toggling -> MISO=0, rx_valid=0, rx_data=0, state IDLE.
- Write address: SS_n low, shift 10'b00_1010_0101 -> single rx_valid pulse with rx_data=10'h0A5 on the 11th edge after SS_n falls. Bits shifted after that produce no further pulse.
- Write data then abort: shift full word 10'b01_0011_1100 -> rx_data=10'h13C. Next frame raises SS_n after 5 bits -> no rx_valid, IDLE next edge, rx_data still 10'h13C.
- Read address, then read data:
  - Read-address frame 10'b10_1010_0101 -> rx_data=10'h2A5, rx_valid pulse, rd_addr_seen=1.
  - Read-data frame 10'b11_0000_0000 -> rx_valid pulse with rx_data=10'h300.
  - Bench returns tx_data=8'hC3 with tx_valid one edge later -> MISO shows 1,1,0,0,0,0,1,1 on consecutive edges; rd_addr_seen then clears.
- Read data without read address (fresh from reset): frame with bit9=1 -> routed to READ_ADD, rx_data=full word, MISO stays 0, rd_addr_seen=1.
- Spurious tx_valid: assert tx_valid=1, tx_data=8'hFF during a WRITE frame -> MISO stays 0, rx_valid behaviour unchanged.
